// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Shared helpers for shift_packer:
//     cnt_width : width of a counter able to hold 0..depth
//     slot_idx  : output slot that receives the k-th word of a pack
// ----------------------------------------------------------------------------
package shift_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // With msb_first the first word lands in the highest slot, so the
    // pack reads most-significant-first when viewed as one wide vector.
    function automatic int unsigned slot_idx(input int unsigned k,
                                             input int unsigned depth,
                                             input bit          msb_first);
        return msb_first ? (depth - 1 - k) : k;
    endfunction

endpackage

// File: rtl/shift_packer.sv
// ----------------------------------------------------------------------------
// shift_packer
//   Collects DEPTH input words of WIDTH bits into one wide packed word.
//   A pack closes early when in_last is accepted; unused slots read zero.
//
//   Ports
//     clk        : clock, all state updates on the rising edge
//     rst_n      : synchronous active-low reset
//     in_valid   : in_data/in_last valid this cycle
//     in_ready   : block accepts a word this cycle
//     in_data    : input word (WIDTH)
//     in_last    : accepted word closes the current pack
//     out_valid  : packed word held on out_data
//     out_ready  : consumer takes the packed word this cycle
//     out_data   : packed word, slot s at [s*WIDTH +: WIDTH]
//     out_cnt    : number of valid words in out_data (1..DEPTH)
// ----------------------------------------------------------------------------
module shift_packer
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned DEPTH     = 8,
    parameter  bit          MSB_FIRST = 1'b0,
    localparam int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*DEPTH-1:0] out_data,
    output logic [CW-1:0]          out_cnt
);

    localparam int unsigned KW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
        $error("shift_packer: DEPTH must be in 2..64");
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
        $error("shift_packer: WIDTH must be in 1..256");
    end

    logic [WIDTH*DEPTH-1:0] coll_data_q, coll_data_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WIDTH*DEPTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic                   out_valid_q, out_valid_d;

    logic [WIDTH*DEPTH-1:0] merged;
    logic [KW-1:0]          slot;
    logic                   accept;
    logic                   consume;
    logic                   complete;

    // Ready depends combinationally on out_ready so a held pack can be
    // replaced in the same cycle it is consumed (no bubble at boundaries).
    assign in_ready  = rst_n && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready;
    assign complete  = in_last || (k_q == KW'(DEPTH - 1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;

    always_comb begin
        slot        = KW'(slot_idx(32'(k_q), DEPTH, MSB_FIRST));
        merged      = coll_data_q;
        merged[slot*WIDTH +: WIDTH] = in_data;

        coll_data_d = coll_data_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        if (accept && complete) begin
            // New pack replaces any pack consumed on this same edge.
            out_data_d  = merged;
            out_cnt_d   = CW'(k_q) + CW'(1);
            out_valid_d = 1'b1;
            k_d         = '0;
            coll_data_d = '0;
        end else begin
            if (accept) begin
                coll_data_d = merged;
                k_d         = k_q + KW'(1);
            end
            if (consume) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_data_q <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            coll_data_q <= coll_data_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_shift_packer.sv
// ----------------------------------------------------------------------------
// tb_shift_packer
//   Drives two shift_packer instances (WIDTH=8, DEPTH=4) with identical
//   stimulus, one LSB-first and one MSB-first, and compares both against a
//   word-list reference model plus directed expected packs.
// ----------------------------------------------------------------------------
module tb_shift_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [2:0]  out_cnt0, out_cnt1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  cur[$];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_d0 = '0;
    logic [31:0] exp_d1 = '0;
    logic [2:0]  exp_cnt = '0;

    always #5 clk = ~clk;

    shift_packer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_cnt(out_cnt0)
    );

    shift_packer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_cnt(out_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready, clock, update model, check outputs.
    task automatic step(input logic rst, input logic v, input logic [7:0] d,
                        input logic l, input logic ordy);
        logic exp_rdy;
        logic acc;
        logic cons;
        @(negedge clk);
        rst_n = rst; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        exp_rdy = rst && (!exp_valid || ordy);
        chk("in_ready_lsb", {63'd0, in_ready0}, {63'd0, exp_rdy});
        chk("in_ready_msb", {63'd0, in_ready1}, {63'd0, exp_rdy});
        @(posedge clk);
        acc  = v && exp_rdy;
        cons = exp_valid && ordy;
        if (!rst) begin
            cur.delete();
            exp_valid = 1'b0; exp_d0 = '0; exp_d1 = '0; exp_cnt = '0;
        end else if (acc) begin
            cur.push_back(d);
            if (cur.size() == 4 || l) begin
                exp_d0 = '0; exp_d1 = '0;
                for (int i = 0; i < cur.size(); i++) begin
                    exp_d0 |= 32'(cur[i]) << (8 * i);
                    exp_d1 |= 32'(cur[i]) << (8 * (3 - i));
                end
                exp_cnt   = 3'(cur.size());
                exp_valid = 1'b1;
                cur.delete();
            end else if (cons) begin
                exp_valid = 1'b0;
            end
        end else if (cons) begin
            exp_valid = 1'b0;
        end
        #1;
        chk("out_valid_lsb", {63'd0, out_valid0}, {63'd0, exp_valid});
        chk("out_valid_msb", {63'd0, out_valid1}, {63'd0, exp_valid});
        chk("out_cnt_lsb", {61'd0, out_cnt0}, {61'd0, exp_cnt});
        chk("out_cnt_msb", {61'd0, out_cnt1}, {61'd0, exp_cnt});
        chk("out_data_lsb", {32'd0, out_data0}, {32'd0, exp_d0});
        chk("out_data_msb", {32'd0, out_data1}, {32'd0, exp_d1});
    endtask

    initial begin
        // reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
        chk("rst_ready", {63'd0, in_ready0}, 64'd0);
        chk("rst_data", {32'd0, out_data0}, 64'd0);
        chk("rst_cnt", {61'd0, out_cnt0}, 64'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ready_after_rst", {63'd0, in_ready0}, 64'd1);

        // full pack, both orders, one-cycle out_valid
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
        chk("p1_valid_early", {63'd0, out_valid0}, 64'd0);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
        chk("p1_lsb", {32'd0, out_data0}, 64'h44332211);
        chk("p1_msb", {32'd0, out_data1}, 64'h11223344);
        chk("p1_cnt", {61'd0, out_cnt0}, 64'd4);
        chk("p1_valid", {63'd0, out_valid0}, 64'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("p1_valid_drop", {63'd0, out_valid0}, 64'd0);
        chk("p1_hold_data", {32'd0, out_data0}, 64'h44332211);

        // partial flush, restart at slot 0, single-word pack
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1);
        chk("flush_lsb", {32'd0, out_data0}, 64'h0000BBAA);
        chk("flush_msb", {32'd0, out_data1}, 64'hAABB0000);
        chk("flush_cnt", {61'd0, out_cnt0}, 64'd2);
        step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b1);
        chk("single_valid", {63'd0, out_valid0}, 64'd1);
        chk("single_lsb", {32'd0, out_data0}, 64'h000000CC);
        chk("single_msb", {32'd0, out_data1}, 64'hCC000000);
        chk("single_cnt", {61'd0, out_cnt0}, 64'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // backpressure: hold pack, input stalls, nothing lost
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
            chk("bp_ready", {63'd0, in_ready0}, 64'd0);
            chk("bp_hold", {32'd0, out_data0}, 64'h44332211);
        end
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h88, 1'b0, 1'b1);
        chk("bp_p2_lsb", {32'd0, out_data0}, 64'h88776655);
        chk("bp_p2_cnt", {61'd0, out_cnt0}, 64'd4);

        // continuous stream, no bubbles
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
            chk("stream_ready", {63'd0, in_ready0}, 64'd1);
            if (i % 4 == 0) begin
                chk("stream_valid", {63'd0, out_valid0}, 64'd1);
                chk("stream_pack", {32'd0, out_data0},
                    {32'd0, 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
            end else if (i > 4) begin
                chk("stream_gap", {63'd0, out_valid0}, 64'd0);
            end
        end

        // reset mid-pack discards the partial words
        step(1'b1, 1'b1, 8'h91, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h92, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b1);
        chk("rstmid_early", {63'd0, out_valid0}, 64'd0);
        step(1'b1, 1'b1, 8'hA4, 1'b0, 1'b1);
        chk("rstmid_pack", {32'd0, out_data0}, 64'hA4A3A2A1);
        chk("rstmid_cnt", {61'd0, out_cnt0}, 64'd4);

        // reset while a pack is held discards it
        step(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rsthold_valid", {63'd0, out_valid0}, 64'd0);
        chk("rsthold_data", {32'd0, out_data0}, 64'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rsthold_nopulse", {63'd0, out_valid0}, 64'd0);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_packer.md
SHIFT_PACKER -- requirements
Module: shift_packer

Interface
REQ-001 Parameter WIDTH, default 32, bits per input word; legal range 1..256.
REQ-002 Parameter DEPTH, default 8, words per packed output; legal range 2..64.
REQ-003 Parameter MSB_FIRST, default 0; 0 = first word at lowest slot, 1 = first word at highest slot.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1, in_data/in_last are valid this cycle.
REQ-007 Port in_ready, output, 1, block accepts a word this cycle.
REQ-008 Port in_data, input, WIDTH, input word.
REQ-009 Port in_last, input, 1, the accepted word closes the current pack (partial flush).
REQ-010 Port out_valid, output, 1, packed word is held on out_data.
REQ-011 Port out_ready, input, 1, consumer takes the packed word this cycle.
REQ-012 Port out_data, output, WIDTH*DEPTH, packed word; slot s occupies bits [s*WIDTH +: WIDTH].
REQ-013 Port out_cnt, output, CW = $clog2(DEPTH+1), number of valid words in out_data (1..DEPTH).

Function
REQ-014 Input beat is accepted when in_valid && in_ready; output beat is consumed when out_valid && out_ready.
REQ-015 in_ready = rst_n && (!out_valid || out_ready); the combinational out_ready->in_ready path is intended.
REQ-016 Collect state: register coll_data (WIDTH*DEPTH) and count k (0..DEPTH-1); the k-th accepted word of a pack goes to slot k (MSB_FIRST=0) or slot DEPTH-1-k (MSB_FIRST=1).
REQ-017 Non-completing accept: write slot, k <= k+1, out_valid unchanged.
REQ-018 Completing accept (k==DEPTH-1, or in_last==1 at any k): on the same edge out_data <= coll_data with the new word merged, out_cnt <= k+1, out_valid <= 1, k <= 0, coll_data <= 0.
REQ-019 Latency: out_valid rises on the edge that accepts the completing word (one cycle after it is presented).
REQ-020 Partial flush: unwritten slots of out_data are zero.
REQ-021 in_last on the first word (k==0) yields a pack with out_cnt=1.
REQ-022 Simultaneous consume and completing accept: the new pack replaces the old one; out_valid stays 1 with no bubble.
REQ-023 Consume without completion: out_valid <= 0; out_data and out_cnt hold their last values.
REQ-024 While out_valid && !out_ready: in_ready=0; coll_data, k, out_data and out_cnt are frozen.
REQ-025 in_data, in_last and in_valid are ignored whenever in_ready=0; no word is ever dropped or duplicated.
REQ-026 Sustained throughput with out_ready held high: one input word per cycle, one pack per DEPTH cycles.

Reset
REQ-027 While rst_n==0 at a rising edge: k=0, coll_data=0, out_data=0, out_cnt=0, out_valid=0.
REQ-028 in_ready is 0 while rst_n is low and 1 in the first cycle after rst_n rises.
REQ-029 Reset during a partial pack or a held output discards both; no out_valid pulse follows reset.

Structure
REQ-030 The shared package shift_pkg holds the count-width helper (CW from DEPTH) and the slot-index function (k, DEPTH, MSB_FIRST -> slot).
REQ-031 The block is a single module with no sub-module; collect and output registers live in shift_packer.
REQ-032 Elaboration-time assertions reject DEPTH<2 and WIDTH<1.

Verification (WIDTH=8, DEPTH=4 unless noted)
REQ-033 Feed 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 -> out_data=0x44332211, out_cnt=4, out_valid exactly one cycle.
REQ-034 Same stimulus with MSB_FIRST=1 -> out_data=0x11223344, out_cnt=4.
REQ-035 Feed 0xAA, then 0xBB with in_last=1 -> out_data=0x0000BBAA, out_cnt=2; next pack restarts at slot 0.
REQ-036 out_ready=0 after the first pack, keep in_valid=1 -> in_ready=0, out_data held; release out_ready -> second pack 0x88776655 arrives with no loss.
REQ-037 Continuous 0x01..0x10 stream with out_ready=1 -> four packs 0x04030201..0x100F0E0D, no bubble at pack boundaries.
REQ-038 Assert rst_n=0 after 2 of 4 words, then feed 4 words -> first out_valid shows only the 4 post-reset words, out_cnt=4.
